// File: rtl/frv_gpr_wb_arb_pkg.sv
// Shared types, widths and bypass helpers for the GPR writeback arbiter.
package frv_gpr_wb_arb_pkg;

    localparam int unsigned FRV_XLEN   = 32;
    localparam int unsigned FRV_REG_AW = 5;

    // One writeback request payload as seen by the arbiter.
    typedef struct packed {
        logic [FRV_REG_AW-1:0] addr;
        logic                  wide;
        logic [FRV_XLEN-1:0]   wdata;
        logic [FRV_XLEN-1:0]   wdata_hi;
    } frv_wb_req_t;

    // A read port hits the in-flight write on its own register or, for a pair write, on the odd partner.
    function automatic logic frv_byp_hit(
        input logic                  rd_wen,
        input logic                  rd_wide,
        input logic [FRV_REG_AW-1:0] rd_addr,
        input logic [FRV_REG_AW-1:0] rs_addr
    );
        return rd_wen && (rs_addr != '0) &&
               ((rs_addr == rd_addr) ||
                (rd_wide && (rs_addr == {rd_addr[FRV_REG_AW-1:1], 1'b1})));
    endfunction

    // Odd register of a pair write takes the high word; everything else takes the low word.
    function automatic logic [FRV_XLEN-1:0] frv_byp_data(
        input logic                rd_wide,
        input logic                rs_lsb,
        input logic [FRV_XLEN-1:0] lo,
        input logic [FRV_XLEN-1:0] hi
    );
        return (rd_wide && rs_lsb) ? hi : lo;
    endfunction

endpackage

// File: rtl/frv_gpr_wb_arb_if.sv
// Writeback request bus, registered GPR write port and read-bypass signals.
interface frv_gpr_wb_arb_if #(
    parameter int unsigned NREQ = 3
);
    import frv_gpr_wb_arb_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*FRV_REG_AW-1:0] req_addr;
    logic [NREQ-1:0]            req_wide;
    logic [NREQ*FRV_XLEN-1:0]   req_wdata;
    logic [NREQ*FRV_XLEN-1:0]   req_wdata_hi;

    logic                       rd_wen;
    logic                       rd_wide;
    logic [FRV_REG_AW-1:0]      rd_addr;
    logic [FRV_XLEN-1:0]        rd_wdata;
    logic [FRV_XLEN-1:0]        rd_wdata_hi;

    logic [FRV_REG_AW-1:0]      rs1_addr;
    logic [FRV_REG_AW-1:0]      rs2_addr;
    logic [FRV_REG_AW-1:0]      rs3_addr;
    logic                       rs1_byp_valid;
    logic                       rs2_byp_valid;
    logic                       rs3_byp_valid;
    logic [FRV_XLEN-1:0]        rs1_byp_data;
    logic [FRV_XLEN-1:0]        rs2_byp_data;
    logic [FRV_XLEN-1:0]        rs3_byp_data;

    logic                       wb_err;

    // Requesters / register-file side.
    modport master (
        output req_valid, req_addr, req_wide, req_wdata, req_wdata_hi,
        output rs1_addr, rs2_addr, rs3_addr,
        input  req_ready,
        input  rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi,
        input  rs1_byp_valid, rs2_byp_valid, rs3_byp_valid,
        input  rs1_byp_data, rs2_byp_data, rs3_byp_data,
        input  wb_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_wide, req_wdata, req_wdata_hi,
        input  rs1_addr, rs2_addr, rs3_addr,
        output req_ready,
        output rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi,
        output rs1_byp_valid, rs2_byp_valid, rs3_byp_valid,
        output rs1_byp_data, rs2_byp_data, rs3_byp_data,
        output wb_err
    );

endinterface

// File: rtl/frv_rr_pick.sv
// Variable-start one-hot priority picker: first set request at or after start_i, wrapping.
module frv_rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    // Walk NREQ positions starting at start_i; the first valid one wins.
    always_comb begin
        int unsigned idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(start_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_o && req_i[IDX_W'(idx)]) begin
                any_o                 = 1'b1;
                gnt_o[IDX_W'(idx)]    = 1'b1;
                gnt_idx_o             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/frv_gpr_wb_arb.sv
// Arbitrates writeback requesters onto the single registered GPR write port and
// bypasses the in-flight write to the three GPR read ports.
module frv_gpr_wb_arb
    import frv_gpr_wb_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter bit          RR_EN = 1'b1
) (
    input  logic               g_clk,
    input  logic               g_reset,
    frv_gpr_wb_arb_if.slave    bus
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    frv_wb_req_t           req [NREQ];
    frv_wb_req_t           sel;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      start_idx;
    logic [NREQ-1:0]       pick_gnt;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  accept;

    logic                  rd_wen_q,      rd_wen_d;
    logic                  rd_wide_q,     rd_wide_d;
    logic [FRV_REG_AW-1:0] rd_addr_q,     rd_addr_d;
    logic [FRV_XLEN-1:0]   rd_wdata_q,    rd_wdata_d;
    logic [FRV_XLEN-1:0]   rd_wdata_hi_q, rd_wdata_hi_d;
    logic                  wb_err_q,      wb_err_d;

    // Unpack the flat request vectors into per-requester payloads.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req[i].addr     = bus.req_addr[i*FRV_REG_AW +: FRV_REG_AW];
            req[i].wide     = bus.req_wide[i];
            req[i].wdata    = bus.req_wdata[i*FRV_XLEN +: FRV_XLEN];
            req[i].wdata_hi = bus.req_wdata_hi[i*FRV_XLEN +: FRV_XLEN];
        end
    end

    // Fixed priority always searches from index 0.
    assign start_idx = RR_EN ? ptr_q : '0;

    frv_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .req_i     (bus.req_valid),
        .start_i   (start_idx),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // The output stage never stalls, so any valid request is accepted unless in reset.
    assign bus.req_ready = g_reset ? '0 : pick_gnt;
    assign accept        = pick_any && !g_reset;
    assign sel           = req[pick_idx];

    // Next pointer, and next write-port contents; data fields hold when idle.
    always_comb begin
        logic wide_ok;
        ptr_d         = ptr_q;
        rd_wen_d      = 1'b0;
        rd_wide_d     = rd_wide_q;
        rd_addr_d     = rd_addr_q;
        rd_wdata_d    = rd_wdata_q;
        rd_wdata_hi_d = rd_wdata_hi_q;
        wb_err_d      = 1'b0;
        wide_ok       = sel.wide && !sel.addr[0];
        if (accept) begin
            if (RR_EN) begin
                ptr_d = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end
            rd_wen_d   = 1'b1;
            rd_wide_d  = wide_ok;
            rd_addr_d  = sel.addr;
            rd_wdata_d = sel.wdata;
            if (wide_ok) begin
                rd_wdata_hi_d = sel.wdata_hi;
            end
            // A pair write to an odd register degrades to a narrow write and is flagged.
            wb_err_d = sel.wide && sel.addr[0];
        end
    end

    // State registers.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            ptr_q         <= '0;
            rd_wen_q      <= 1'b0;
            rd_wide_q     <= 1'b0;
            rd_addr_q     <= '0;
            rd_wdata_q    <= '0;
            rd_wdata_hi_q <= '0;
            wb_err_q      <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            rd_wen_q      <= rd_wen_d;
            rd_wide_q     <= rd_wide_d;
            rd_addr_q     <= rd_addr_d;
            rd_wdata_q    <= rd_wdata_d;
            rd_wdata_hi_q <= rd_wdata_hi_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign bus.rd_wen      = rd_wen_q;
    assign bus.rd_wide     = rd_wide_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.rd_wdata    = rd_wdata_q;
    assign bus.rd_wdata_hi = rd_wdata_hi_q;
    assign bus.wb_err      = wb_err_q;

    // Read-port bypass from the registered write port.
    assign bus.rs1_byp_valid = frv_byp_hit(rd_wen_q, rd_wide_q, rd_addr_q, bus.rs1_addr);
    assign bus.rs2_byp_valid = frv_byp_hit(rd_wen_q, rd_wide_q, rd_addr_q, bus.rs2_addr);
    assign bus.rs3_byp_valid = frv_byp_hit(rd_wen_q, rd_wide_q, rd_addr_q, bus.rs3_addr);
    assign bus.rs1_byp_data  = frv_byp_data(rd_wide_q, bus.rs1_addr[0], rd_wdata_q, rd_wdata_hi_q);
    assign bus.rs2_byp_data  = frv_byp_data(rd_wide_q, bus.rs2_addr[0], rd_wdata_q, rd_wdata_hi_q);
    assign bus.rs3_byp_data  = frv_byp_data(rd_wide_q, bus.rs3_addr[0], rd_wdata_q, rd_wdata_hi_q);

endmodule

// File: tb/tb_frv_gpr_wb_arb.sv
// Directed bench: a round-robin and a fixed-priority instance driven with identical stimulus.
module tb_frv_gpr_wb_arb;

    logic        g_clk;
    logic        g_reset;

    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [2:0]  req_wide;
    logic [95:0] req_wdata;
    logic [95:0] req_wdata_hi;
    logic [4:0]  rs1_addr, rs2_addr, rs3_addr;

    int checks = 0;
    int errors = 0;

    frv_gpr_wb_arb_if #(.NREQ(3)) bus_rr ();
    frv_gpr_wb_arb_if #(.NREQ(3)) bus_fp ();

    assign bus_rr.req_valid    = req_valid;
    assign bus_rr.req_addr     = req_addr;
    assign bus_rr.req_wide     = req_wide;
    assign bus_rr.req_wdata    = req_wdata;
    assign bus_rr.req_wdata_hi = req_wdata_hi;
    assign bus_rr.rs1_addr     = rs1_addr;
    assign bus_rr.rs2_addr     = rs2_addr;
    assign bus_rr.rs3_addr     = rs3_addr;

    assign bus_fp.req_valid    = req_valid;
    assign bus_fp.req_addr     = req_addr;
    assign bus_fp.req_wide     = req_wide;
    assign bus_fp.req_wdata    = req_wdata;
    assign bus_fp.req_wdata_hi = req_wdata_hi;
    assign bus_fp.rs1_addr     = rs1_addr;
    assign bus_fp.rs2_addr     = rs2_addr;
    assign bus_fp.rs3_addr     = rs3_addr;

    frv_gpr_wb_arb #(.NREQ(3), .RR_EN(1'b1)) u_rr (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus_rr)
    );

    frv_gpr_wb_arb #(.NREQ(3), .RR_EN(1'b0)) u_fp (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus_fp)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [4:0] a, input logic w,
                           input logic [31:0] lo, input logic [31:0] hi);
        req_addr[i*5 +: 5]      = a;
        req_wide[i]             = w;
        req_wdata[i*32 +: 32]   = lo;
        req_wdata_hi[i*32 +: 32] = hi;
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        g_reset   = 1'b1;
        req_valid = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rs3_addr  = '0;
        repeat (2) @(posedge g_clk);
        #1;
        g_reset = 1'b0;
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 1'b0, 32'h100 + i, 32'h0);
        req_valid = 3'b111;
        rs1_addr = '0; rs2_addr = '0; rs3_addr = '0;
        #2;
        checks++; if (bus_rr.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_rr: got %b expected 000", bus_rr.req_ready); end
        checks++; if (bus_fp.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_fp: got %b expected 000", bus_fp.req_ready); end
        step();
        checks++; if (bus_rr.rd_wen !== 1'b0) begin errors++; $display("FAIL reset_rd_wen: got %b expected 0", bus_rr.rd_wen); end
        checks++; if (bus_rr.rd_wide !== 1'b0) begin errors++; $display("FAIL reset_rd_wide: got %b expected 0", bus_rr.rd_wide); end
        checks++; if (bus_rr.rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 0", bus_rr.rd_addr); end
        checks++; if (bus_rr.rd_wdata !== 32'h0) begin errors++; $display("FAIL reset_rd_wdata: got %h expected 0", bus_rr.rd_wdata); end
        checks++; if (bus_rr.rd_wdata_hi !== 32'h0) begin errors++; $display("FAIL reset_rd_wdata_hi: got %h expected 0", bus_rr.rd_wdata_hi); end
        checks++; if (bus_rr.wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err: got %b expected 0", bus_rr.wb_err); end
        checks++; if ({bus_rr.rs1_byp_valid, bus_rr.rs2_byp_valid, bus_rr.rs3_byp_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_byp_valid: got %b expected 000",
                {bus_rr.rs1_byp_valid, bus_rr.rs2_byp_valid, bus_rr.rs3_byp_valid}); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt;
        int prev;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 1'b0, 32'h100 + i, 32'h0);
        req_valid = 3'b111;
        for (int k = 0; k <= 6; k++) begin
            @(negedge g_clk);
            if (k < 6) begin
                exp_gnt = 3'(1 << (k % 3));
                checks++; if (bus_rr.req_ready !== exp_gnt) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, bus_rr.req_ready, exp_gnt); end
            end
            if (k > 0) begin
                prev = (k - 1) % 3;
                checks++; if (bus_rr.rd_wen !== 1'b1 || bus_rr.rd_addr !== 5'(10 + prev) || bus_rr.rd_wdata !== 32'(32'h100 + prev)) begin
                    errors++; $display("FAIL rr_write%0d: got wen=%b addr=%0d data=%h expected wen=1 addr=%0d data=%h",
                        k, bus_rr.rd_wen, bus_rr.rd_addr, bus_rr.rd_wdata, 10 + prev, 32'h100 + prev); end
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_fixed_prio();
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 1'b0, 32'h100 + i, 32'h0);
        req_valid = 3'b111;
        for (int k = 0; k <= 6; k++) begin
            @(negedge g_clk);
            if (k < 6) begin
                checks++; if (bus_fp.req_ready !== 3'b001) begin errors++; $display("FAIL fp_grant%0d: got %b expected 001", k, bus_fp.req_ready); end
            end
            if (k > 0) begin
                checks++; if (bus_fp.rd_wen !== 1'b1 || bus_fp.rd_addr !== 5'd10 || bus_fp.rd_wdata !== 32'h100) begin
                    errors++; $display("FAIL fp_write%0d: got wen=%b addr=%0d data=%h expected wen=1 addr=10 data=100",
                        k, bus_fp.rd_wen, bus_fp.rd_addr, bus_fp.rd_wdata); end
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_wide_bypass();
        do_reset();
        set_req(1, 5'd6, 1'b1, 32'hA, 32'hB);
        req_valid = 3'b010;
        @(negedge g_clk);
        checks++; if (bus_rr.req_ready !== 3'b010) begin errors++; $display("FAIL wide_grant: got %b expected 010", bus_rr.req_ready); end
        step();
        req_valid = '0;
        rs1_addr = 5'd6; rs2_addr = 5'd7; rs3_addr = 5'd8;
        @(negedge g_clk);
        checks++; if (bus_rr.rd_wen !== 1'b1 || bus_rr.rd_wide !== 1'b1 || bus_rr.rd_addr !== 5'd6) begin
            errors++; $display("FAIL wide_write: got wen=%b wide=%b addr=%0d expected wen=1 wide=1 addr=6",
                bus_rr.rd_wen, bus_rr.rd_wide, bus_rr.rd_addr); end
        checks++; if ({bus_rr.rs1_byp_valid, bus_rr.rs2_byp_valid, bus_rr.rs3_byp_valid} !== 3'b110) begin
            errors++; $display("FAIL wide_byp_valid: got %b expected 110",
                {bus_rr.rs1_byp_valid, bus_rr.rs2_byp_valid, bus_rr.rs3_byp_valid}); end
        checks++; if (bus_rr.rs1_byp_data !== 32'hA) begin errors++; $display("FAIL wide_byp1_data: got %h expected 0000000a", bus_rr.rs1_byp_data); end
        checks++; if (bus_rr.rs2_byp_data !== 32'hB) begin errors++; $display("FAIL wide_byp2_data: got %h expected 0000000b", bus_rr.rs2_byp_data); end
        step();
        @(negedge g_clk);
        checks++; if (bus_rr.rd_wen !== 1'b0 || bus_rr.rs1_byp_valid !== 1'b0) begin
            errors++; $display("FAIL idle_wen: got wen=%b byp1=%b expected 0 0", bus_rr.rd_wen, bus_rr.rs1_byp_valid); end
        checks++; if (bus_rr.rd_wdata !== 32'hA || bus_rr.rd_wdata_hi !== 32'hB || bus_rr.rd_addr !== 5'd6) begin
            errors++; $display("FAIL idle_hold: got addr=%0d lo=%h hi=%h expected 6 a b",
                bus_rr.rd_addr, bus_rr.rd_wdata, bus_rr.rd_wdata_hi); end
        rs1_addr = '0; rs2_addr = '0; rs3_addr = '0;
    endtask

    task automatic test_misaligned_wide();
        do_reset();
        set_req(2, 5'd5, 1'b1, 32'h55, 32'hDEAD_BEEF);
        req_valid = 3'b100;
        rs1_addr = 5'd5; rs2_addr = 5'd4; rs3_addr = 5'd0;
        @(negedge g_clk);
        checks++; if (bus_rr.req_ready !== 3'b100) begin errors++; $display("FAIL mis_grant: got %b expected 100", bus_rr.req_ready); end
        checks++; if (bus_rr.wb_err !== 1'b0) begin errors++; $display("FAIL mis_err_early: got %b expected 0", bus_rr.wb_err); end
        step();
        req_valid = '0;
        @(negedge g_clk);
        checks++; if (bus_rr.rd_wen !== 1'b1 || bus_rr.rd_wide !== 1'b0 || bus_rr.rd_addr !== 5'd5 || bus_rr.rd_wdata !== 32'h55) begin
            errors++; $display("FAIL mis_write: got wen=%b wide=%b addr=%0d lo=%h expected 1 0 5 00000055",
                bus_rr.rd_wen, bus_rr.rd_wide, bus_rr.rd_addr, bus_rr.rd_wdata); end
        checks++; if (bus_rr.rd_wdata_hi !== 32'h0) begin errors++; $display("FAIL mis_hi: got %h expected 00000000", bus_rr.rd_wdata_hi); end
        checks++; if (bus_rr.wb_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", bus_rr.wb_err); end
        checks++; if (bus_rr.rs1_byp_valid !== 1'b1 || bus_rr.rs1_byp_data !== 32'h55 || bus_rr.rs2_byp_valid !== 1'b0) begin
            errors++; $display("FAIL mis_byp: got v1=%b d1=%h v2=%b expected 1 00000055 0",
                bus_rr.rs1_byp_valid, bus_rr.rs1_byp_data, bus_rr.rs2_byp_valid); end
        step();
        @(negedge g_clk);
        checks++; if (bus_rr.wb_err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse: got %b expected 0", bus_rr.wb_err); end
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic test_x0();
        do_reset();
        set_req(0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        req_valid = 3'b001;
        rs1_addr = 5'd0; rs2_addr = 5'd1; rs3_addr = 5'd0;
        step();
        set_req(0, 5'd0, 1'b1, 32'h11, 32'h1234);
        @(negedge g_clk);
        checks++; if (bus_rr.rd_wen !== 1'b1 || bus_rr.rd_addr !== 5'd0 || bus_rr.rd_wdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL x0_write: got wen=%b addr=%0d lo=%h expected 1 0 ffffffff",
                bus_rr.rd_wen, bus_rr.rd_addr, bus_rr.rd_wdata); end
        checks++; if (bus_rr.rs1_byp_valid !== 1'b0 || bus_rr.rs2_byp_valid !== 1'b0) begin
            errors++; $display("FAIL x0_byp: got v1=%b v2=%b expected 0 0", bus_rr.rs1_byp_valid, bus_rr.rs2_byp_valid); end
        step();
        req_valid = '0;
        @(negedge g_clk);
        checks++; if (bus_rr.rd_wide !== 1'b1 || bus_rr.rd_addr !== 5'd0 || bus_rr.rd_wdata_hi !== 32'h1234) begin
            errors++; $display("FAIL x0_wide: got wide=%b addr=%0d hi=%h expected 1 0 00001234",
                bus_rr.rd_wide, bus_rr.rd_addr, bus_rr.rd_wdata_hi); end
        checks++; if (bus_rr.rs2_byp_valid !== 1'b1 || bus_rr.rs2_byp_data !== 32'h1234 || bus_rr.rs1_byp_valid !== 1'b0) begin
            errors++; $display("FAIL x0_wide_byp: got v2=%b d2=%h v1=%b expected 1 00001234 0",
                bus_rr.rs2_byp_valid, bus_rr.rs2_byp_data, bus_rr.rs1_byp_valid); end
        rs2_addr = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 1'b0, 32'h100 + i, 32'h0);
        req_valid = 3'b111;
        step();
        #2;
        checks++; if (bus_rr.req_ready !== 3'b010 || bus_rr.rd_wen !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got ready=%b wen=%b expected 010 1", bus_rr.req_ready, bus_rr.rd_wen); end
        g_reset = 1'b1;
        #1;
        checks++; if (bus_rr.rd_wen !== 1'b0 || bus_rr.req_ready !== 3'b000 || bus_rr.rd_addr !== 5'd0 || bus_rr.rd_wdata !== 32'h0) begin
            errors++; $display("FAIL mid_async: got wen=%b ready=%b addr=%0d lo=%h expected 0 000 0 0",
                bus_rr.rd_wen, bus_rr.req_ready, bus_rr.rd_addr, bus_rr.rd_wdata); end
        step();
        req_valid = 3'b101;
        checks++; if (bus_rr.rd_wen !== 1'b0) begin errors++; $display("FAIL mid_no_wen: got %b expected 0", bus_rr.rd_wen); end
        #1;
        g_reset = 1'b0;
        @(negedge g_clk);
        checks++; if (bus_rr.req_ready !== 3'b001 || bus_fp.req_ready !== 3'b001) begin
            errors++; $display("FAIL mid_first_grant: got rr=%b fp=%b expected 001 001", bus_rr.req_ready, bus_fp.req_ready); end
        checks++; if (bus_rr.rd_wen !== 1'b0) begin errors++; $display("FAIL mid_wen_after: got %b expected 0", bus_rr.rd_wen); end
        step();
        req_valid = '0;
        @(negedge g_clk);
        checks++; if (bus_rr.rd_wen !== 1'b1 || bus_rr.rd_addr !== 5'd10) begin
            errors++; $display("FAIL mid_resume: got wen=%b addr=%0d expected 1 10", bus_rr.rd_wen, bus_rr.rd_addr); end
    endtask

    initial begin
        g_reset      = 1'b1;
        req_valid    = '0;
        req_addr     = '0;
        req_wide     = '0;
        req_wdata    = '0;
        req_wdata_hi = '0;
        rs1_addr     = '0;
        rs2_addr     = '0;
        rs3_addr     = '0;
        test_reset();
        test_round_robin();
        test_fixed_prio();
        test_wide_bypass();
        test_misaligned_wide();
        test_x0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
